fetch2: RTL and testbench

Second fetch stage. Sits between `fetch1` and decode. Each cycle it captures the two-instruction fetch packet (PC, instruction words, BTB/PHT predictions), kills the slot after a predicted-taken slot 0, and queues packets in a small FIFO. The FIFO decouples fetch from decode stalls, drives backpressure into `fetch1`'s `pc_we_i`, and is flushed on misprediction.

---
 rtl/fetch2_pkg.sv | 40 ++++
 rtl/fetch_queue.sv | 73 +++++++
 rtl/fetch2.sv | 71 +++++++
 tb/tb_fetch2.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch2_pkg.sv
// Shared types for the second fetch stage: queued packet layout and packing.
package fetch2_pkg;

  // One queued fetch packet, MSB first: pc, instr_0, instr_1, slot_v, pred, tgt.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr_0;
    logic [31:0] instr_1;
    logic [1:0]  slot_v;
    logic [1:0]  pred;
    logic [31:0] tgt;
  } fq_entry_t;

  localparam int FQ_ENTRY_W = $bits(fq_entry_t);

  // Build a queue entry from a raw fetch packet. A taken slot 0 kills slot 1,
  // and the recorded target is that of the first taken slot (0 if none).
  function automatic fq_entry_t fq_pack(input logic [31:0] pc,
                                        input logic [63:0] rdata,
                                        input logic        pred_0,
                                        input logic        pred_1,
                                        input logic [31:0] tgt_0,
                                        input logic [31:0] tgt_1);
    fq_entry_t e;
    e.pc      = pc;
    e.instr_0 = rdata[31:0];
    e.instr_1 = rdata[63:32];
    e.slot_v  = {!pred_0, 1'b1};
    e.pred    = {pred_1 && !pred_0, pred_0};
    if (pred_0) begin
      e.tgt = tgt_0;
    end else if (pred_1) begin
      e.tgt = tgt_1;
    end else begin
      e.tgt = 32'h0;
    end
    return e;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Generic synchronous FIFO with flush. Storage is not reset; validity is
// tracked purely by the read/write pointers (extra MSB distinguishes full/empty).
module fetch_queue #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   push_i,
  input  logic                   pop_i,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       data_i,
  output logic [WIDTH-1:0]       head_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int IW = $clog2(DEPTH);
  localparam logic [IW:0] ONE_C = (IW+1)'(1);

  logic [IW:0]      wr_ptr_r;
  logic [IW:0]      rd_ptr_r;
  logic [IW:0]      count_r;
  logic [WIDTH-1:0] mem_r [DEPTH];

  // Pointer and occupancy bookkeeping; flush returns the queue to empty.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else if (flush_i) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_i) begin
        wr_ptr_r <= wr_ptr_r + ONE_C;
      end
      if (pop_i) begin
        rd_ptr_r <= rd_ptr_r + ONE_C;
      end
      case ({push_i, pop_i})
        2'b10:   count_r <= count_r + ONE_C;
        2'b01:   count_r <= count_r - ONE_C;
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage write; a push that coincides with flush is discarded.
  always_ff @(posedge clock_i) begin
    if (push_i && !flush_i) begin
      mem_r[wr_ptr_r[IW-1:0]] <= data_i;
    end
  end

  assign empty_o = (wr_ptr_r == rd_ptr_r);
  assign full_o  = (wr_ptr_r[IW-1:0] == rd_ptr_r[IW-1:0]) && (wr_ptr_r[IW] != rd_ptr_r[IW]);
  assign count_o = count_r;

  // Head read; forced to zero when nothing is queued so stale storage never leaks.
  always_comb begin
    head_o = '0;
    if (!empty_o) begin
      head_o = mem_r[rd_ptr_r[IW-1:0]];
    end else begin
      head_o = '0;
    end
  end

endmodule

// File: rtl/fetch2.sv
// Second fetch stage: masks the fetch packet by its predictions and queues it
// for decode, providing backpressure to fetch1 and flushing on redirect.
module fetch2
  import fetch2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   fetch_valid_i,
  output logic                   fetch_ready_o,
  input  logic [31:0]            pc_i,
  input  logic [63:0]            imem_rdata_i,
  input  logic                   pred_0_i,
  input  logic                   pred_1_i,
  input  logic [31:0]            pred_tgt_0_i,
  input  logic [31:0]            pred_tgt_1_i,
  input  logic                   flush_i,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [31:0]            out_pc_o,
  output logic [31:0]            out_instr_0_o,
  output logic [31:0]            out_instr_1_o,
  output logic [1:0]             out_slot_v_o,
  output logic [1:0]             out_pred_o,
  output logic [31:0]            out_pred_tgt_o,
  output logic [$clog2(DEPTH):0] occupancy_o
);

  fq_entry_t entry_s;
  fq_entry_t head_s;
  logic      enq_s;
  logic      deq_s;
  logic      full_s;
  logic      empty_s;

  // Apply slot masking and target selection to the incoming packet.
  always_comb begin
    entry_s = fq_pack(pc_i, imem_rdata_i, pred_0_i, pred_1_i, pred_tgt_0_i, pred_tgt_1_i);
  end

  // A full queue still accepts when the head leaves in the same cycle.
  assign out_valid_o   = !empty_s;
  assign fetch_ready_o = !full_s || (out_valid_o && out_ready_i);
  assign enq_s         = fetch_valid_i && fetch_ready_o && !flush_i;
  assign deq_s         = out_valid_o && out_ready_i && !flush_i;

  fetch_queue #(
    .WIDTH (FQ_ENTRY_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clock_i  (clock_i),
    .reset_ni (reset_ni),
    .push_i   (enq_s),
    .pop_i    (deq_s),
    .flush_i  (flush_i),
    .data_i   (entry_s),
    .head_o   (head_s),
    .full_o   (full_s),
    .empty_o  (empty_s),
    .count_o  (occupancy_o)
  );

  assign out_pc_o       = head_s.pc;
  assign out_instr_0_o  = head_s.instr_0;
  assign out_instr_1_o  = head_s.instr_1;
  assign out_slot_v_o   = head_s.slot_v;
  assign out_pred_o     = head_s.pred;
  assign out_pred_tgt_o = head_s.tgt;

endmodule

// File: tb/tb_fetch2.sv
// Self-checking bench for fetch2: directed cases with literal expectations plus
// randomized traffic checked every cycle against a queue-based packet model.
module tb_fetch2;

  localparam int DEPTH = 4;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        fetch_valid_i = 1'b0;
  logic        fetch_ready_o;
  logic [31:0] pc_i = 32'h0;
  logic [63:0] imem_rdata_i = 64'h0;
  logic        pred_0_i = 1'b0;
  logic        pred_1_i = 1'b0;
  logic [31:0] pred_tgt_0_i = 32'h0;
  logic [31:0] pred_tgt_1_i = 32'h0;
  logic        flush_i = 1'b0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b0;
  logic [31:0] out_pc_o;
  logic [31:0] out_instr_0_o;
  logic [31:0] out_instr_1_o;
  logic [1:0]  out_slot_v_o;
  logic [1:0]  out_pred_o;
  logic [31:0] out_pred_tgt_o;
  logic [$clog2(DEPTH):0] occupancy_o;

  always #5 clock_i = ~clock_i;

  fetch2 #(.DEPTH(DEPTH)) dut (
    .clock_i        (clock_i),
    .reset_ni       (reset_ni),
    .fetch_valid_i  (fetch_valid_i),
    .fetch_ready_o  (fetch_ready_o),
    .pc_i           (pc_i),
    .imem_rdata_i   (imem_rdata_i),
    .pred_0_i       (pred_0_i),
    .pred_1_i       (pred_1_i),
    .pred_tgt_0_i   (pred_tgt_0_i),
    .pred_tgt_1_i   (pred_tgt_1_i),
    .flush_i        (flush_i),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_pc_o       (out_pc_o),
    .out_instr_0_o  (out_instr_0_o),
    .out_instr_1_o  (out_instr_1_o),
    .out_slot_v_o   (out_slot_v_o),
    .out_pred_o     (out_pred_o),
    .out_pred_tgt_o (out_pred_tgt_o),
    .occupancy_o    (occupancy_o)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  sv;
    logic [1:0]  pr;
    logic [31:0] tgt;
  } pkt_t;

  pkt_t model_q[$];
  int   checks = 0;
  int   errors = 0;
  logic last_acc = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // What decode must eventually see for the packet currently on the inputs.
  function automatic pkt_t make_pkt();
    pkt_t p;
    p.pc = pc_i;
    p.i0 = imem_rdata_i[31:0];
    p.i1 = imem_rdata_i[63:32];
    if (pred_0_i) begin
      p.sv = 2'b01; p.pr = 2'b01; p.tgt = pred_tgt_0_i;
    end else if (pred_1_i) begin
      p.sv = 2'b11; p.pr = 2'b10; p.tgt = pred_tgt_1_i;
    end else begin
      p.sv = 2'b11; p.pr = 2'b00; p.tgt = 32'h0;
    end
    return p;
  endfunction

  // Every-cycle comparison against the model, then model update for the coming edge.
  always @(negedge clock_i) begin
    int   n;
    logic exp_ready;
    if (reset_ni) begin
      n = model_q.size();
      exp_ready = (n < DEPTH) || (n > 0 && out_ready_i);
      chk("out_valid", out_valid_o, (n > 0) ? 32'd1 : 32'd0);
      chk("occupancy", occupancy_o, n);
      chk("fetch_ready", fetch_ready_o, exp_ready);
      if (n > 0) begin
        chk("out_pc", out_pc_o, model_q[0].pc);
        chk("out_instr_0", out_instr_0_o, model_q[0].i0);
        chk("out_instr_1", out_instr_1_o, model_q[0].i1);
        chk("out_slot_v", out_slot_v_o, model_q[0].sv);
        chk("out_pred", out_pred_o, model_q[0].pr);
        chk("out_pred_tgt", out_pred_tgt_o, model_q[0].tgt);
      end else begin
        chk("empty_data", out_pc_o | out_instr_0_o | out_instr_1_o | out_pred_tgt_o |
            {28'd0, out_slot_v_o, out_pred_o}, 32'h0);
      end
      if (flush_i) begin
        model_q.delete();
        last_acc = 1'b0;
      end else begin
        last_acc = fetch_valid_i && exp_ready;
        if (n > 0 && out_ready_i) void'(model_q.pop_front());
        if (last_acc) model_q.push_back(make_pkt());
      end
    end
  end

  task automatic cyc();
    @(posedge clock_i);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic p0, input logic p1,
                       input logic [31:0] t0, input logic [31:0] t1);
    fetch_valid_i = v;
    pc_i          = pc;
    imem_rdata_i  = {pc ^ 32'hA5A5_0000, pc + 32'h13};
    pred_0_i      = p0;
    pred_1_i      = p1;
    pred_tgt_0_i  = t0;
    pred_tgt_1_i  = t1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clock_i);
    #3 reset_ni = 1'b1;
    #1;
    chk("rst_valid", out_valid_o, 32'd0);
    chk("rst_occ", occupancy_o, 32'd0);
    chk("rst_ready", fetch_ready_o, 32'd1);
    chk("rst_pc", out_pc_o, 32'h0);
    cyc();

    // Basic flow
    fetch_valid_i = 1'b1; pc_i = 32'h100;
    imem_rdata_i = {32'h00000013, 32'h00100093};
    out_ready_i = 1'b1;
    cyc();
    fetch_valid_i = 1'b0;
    chk("basic_valid", out_valid_o, 32'd1);
    chk("basic_pc", out_pc_o, 32'h100);
    chk("basic_i0", out_instr_0_o, 32'h00100093);
    chk("basic_i1", out_instr_1_o, 32'h00000013);
    chk("basic_sv", out_slot_v_o, 32'd3);
    chk("basic_pr", out_pred_o, 32'd0);
    chk("basic_tgt", out_pred_tgt_o, 32'h0);
    chk("basic_occ", occupancy_o, 32'd1);
    cyc();
    chk("basic_drain", occupancy_o, 32'd0);

    // Slot 0 taken kills slot 1
    out_ready_i = 1'b0;
    drive(1'b1, 32'h40, 1'b1, 1'b1, 32'h200, 32'h7fc);
    cyc();
    fetch_valid_i = 1'b0;
    chk("s0_sv", out_slot_v_o, 32'd1);
    chk("s0_pr", out_pred_o, 32'd1);
    chk("s0_tgt", out_pred_tgt_o, 32'h200);
    out_ready_i = 1'b1;
    cyc();

    // Slot 1 taken
    out_ready_i = 1'b0;
    drive(1'b1, 32'h80, 1'b0, 1'b1, 32'h0, 32'h340);
    cyc();
    fetch_valid_i = 1'b0;
    chk("s1_sv", out_slot_v_o, 32'd3);
    chk("s1_pr", out_pred_o, 32'd2);
    chk("s1_tgt", out_pred_tgt_o, 32'h340);
    out_ready_i = 1'b1;
    cyc();

    // Fill and drain
    out_ready_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 32'(k * 8), 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
    end
    chk("fill_occ", occupancy_o, 32'd4);
    chk("fill_ready", fetch_ready_o, 32'd0);
    chk("fill_head", out_pc_o, 32'h0);
    cyc();
    chk("hold_occ", occupancy_o, 32'd4);
    chk("hold_pc_in", pc_i, 32'h20);
    out_ready_i = 1'b1;
    #1;
    chk("full_deq_ready", fetch_ready_o, 32'd1);
    cyc();
    out_ready_i = 1'b0;
    fetch_valid_i = 1'b0;
    chk("swap_occ", occupancy_o, 32'd4);
    chk("swap_head", out_pc_o, 32'h8);
    out_ready_i = 1'b1;
    for (int k = 1; k < 5; k++) begin
      chk("drain_pc", out_pc_o, 32'(k * 8));
      cyc();
    end
    chk("drain_empty", occupancy_o, 32'd0);

    // Flush with simultaneous fetch and decode
    out_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 32'h300 + 32'(k * 8), 1'b0, 1'b0, 32'h0, 32'h0);
      cyc();
    end
    chk("pre_flush_occ", occupancy_o, 32'd3);
    drive(1'b1, 32'h500, 1'b0, 1'b0, 32'h0, 32'h0);
    out_ready_i = 1'b1;
    flush_i = 1'b1;
    cyc();
    flush_i = 1'b0;
    out_ready_i = 1'b0;
    chk("flush_occ", occupancy_o, 32'd0);
    chk("flush_valid", out_valid_o, 32'd0);
    drive(1'b1, 32'h600, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    fetch_valid_i = 1'b0;
    chk("post_flush_valid", out_valid_o, 32'd1);
    chk("post_flush_pc", out_pc_o, 32'h600);
    chk("post_flush_occ", occupancy_o, 32'd1);
    out_ready_i = 1'b1;
    cyc();

    // Asynchronous reset mid-operation
    out_ready_i = 1'b0;
    drive(1'b1, 32'h700, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    drive(1'b1, 32'h708, 1'b0, 1'b0, 32'h0, 32'h0);
    cyc();
    fetch_valid_i = 1'b0;
    chk("pre_rst_occ", occupancy_o, 32'd2);
    #1 reset_ni = 1'b0;
    #1;
    chk("async_valid", out_valid_o, 32'd0);
    chk("async_occ", occupancy_o, 32'd0);
    model_q.delete();
    last_acc = 1'b0;
    #1 reset_ni = 1'b1;
    cyc();

    // Randomized traffic with fetch1-style holding under backpressure
    for (int c = 0; c < 600; c++) begin
      if (!(fetch_valid_i && !last_acc)) begin
        drive($urandom_range(0, 3) != 0, $urandom() & 32'hFFFF_FFFC,
              $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
              $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC);
        imem_rdata_i = {$urandom(), $urandom()};
      end
      out_ready_i = (c < 300) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
      flush_i = ($urandom_range(0, 24) == 0);
      cyc();
    end
    fetch_valid_i = 1'b0;
    flush_i = 1'b0;
    out_ready_i = 1'b1;
    repeat (6) cyc();
    chk("final_empty", occupancy_o, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
